xyj_panel_ctrl: RTL

- Front-panel control stage feeding the washer sequencer (wash 25 / pause 5 / wash 25 / pause 5 chain).
- Turns raw start/stop push-buttons into clean one-cycle events and runs an IDLE/RUN/PAUSE/DONE state machine.
- Drives the sequencer's start pulse, stop level and clear pulse.
- Consumes the sequencer's end-of-cycle flag to sound a completion buzzer and return to idle.

---
 rtl/xyj_panel_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/xyj_panel_ctrl.sv
// rtl/xyj_panel_ctrl.sv - front-panel key debounce and run/pause/done control for the washer sequencer
module xyj_panel_ctrl #(
    parameter logic [19:0] DEB_CYCLES  = 20'd500000,
    parameter logic [23:0] BUZZ_CYCLES = 24'd5000000,
    parameter int          CNT_W       = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic key_start,
    input  logic key_stop,
    input  logic cycle_done,
    output logic open,
    output logic i_stop,
    output logic clr,
    output logic led_run,
    output logic led_pause,
    output logic buzz
);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 20'd1);
    localparam logic [CNT_W-1:0] BUZZ_LAST = CNT_W'(BUZZ_CYCLES - 24'd1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state;
    logic [1:0]       keys;
    logic [1:0]       key_ev;
    logic             start_ev;
    logic             stop_ev;
    logic [CNT_W-1:0] buzz_cnt;

    assign keys = {key_stop, key_start};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic             sync0;
        logic             sync1;
        logic             level;
        logic             level_q;
        logic             ev;
        logic [CNT_W-1:0] cnt;

        // Any return to the accepted level restarts the count, so short glitches never flip it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync0   <= 1'b0;
                sync1   <= 1'b0;
                level   <= 1'b0;
                level_q <= 1'b0;
                ev      <= 1'b0;
                cnt     <= '0;
            end else begin
                sync0   <= keys[k];
                sync1   <= sync0;
                level_q <= level;
                ev      <= level & ~level_q;
                if (sync1 == level) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    level <= sync1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign key_ev[k] = ev;
    end

    assign start_ev = key_ev[0];
    assign stop_ev  = key_ev[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            open     <= 1'b0;
            i_stop   <= 1'b0;
            clr      <= 1'b0;
            buzz     <= 1'b0;
            buzz_cnt <= '0;
        end else begin
            open <= 1'b0;
            clr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ev && !stop_ev) begin
                        state <= RUN;
                        open  <= 1'b1;
                    end
                end
                RUN: begin
                    // A finished cycle outranks a stop arriving on the same clock.
                    if (cycle_done) begin
                        state    <= DONE;
                        buzz_cnt <= BUZZ_LAST;
                        buzz     <= 1'b1;
                    end else if (stop_ev) begin
                        state  <= PAUSE;
                        i_stop <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop_ev) begin
                        state  <= IDLE;
                        clr    <= 1'b1;
                        i_stop <= 1'b0;
                    end else if (start_ev) begin
                        state  <= RUN;
                        i_stop <= 1'b0;
                    end
                end
                DONE: begin
                    if (start_ev || stop_ev || buzz_cnt == '0) begin
                        state <= IDLE;
                        buzz  <= 1'b0;
                        clr   <= 1'b1;
                    end else begin
                        buzz_cnt <= buzz_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign led_run   = (state == RUN);
    assign led_pause = (state == PAUSE);
endmodule
